// File: rtl/ahb_pll_reg_bridge.sv
// AHB-Lite slave bridging single-word transfers onto the PLL register-bus
// valid/ready handshake. Single clock (i_clk_ahb), synchronous active-high reset.
// Optional build macro AHB_BRIDGE_TIMEOUT_EN: abandons a register request that
// has not completed within TIMEOUT_CYC cycles and answers the master with ERROR.
module ahb_pll_reg_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              i_clk_ahb,
    input  logic              reset,
    // AHB-Lite slave side
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HRESP,
    // Register side
    output logic [ADDR_W-1:0] o_address,
    output logic              o_rd0_wr1,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_REQ,
        S_RWAIT,
        S_RESP,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic legal;
    logic rd_capture;
    logic timeout;
    logic unused_ok;

    // A new address phase is only looked at when the data phase of the
    // previous transfer is finishing (IDLE) or completing OKAY (RESP).
    assign accept = ((state == S_IDLE) || (state == S_RESP)) && HSEL && HREADY && HTRANS[1];
    assign legal  = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

    // Read data is taken either together with the request handshake or later in RWAIT.
    assign rd_capture = !o_rd0_wr1 && i_rd_valid &&
                        (((state == S_REQ) && i_ready) || (state == S_RWAIT));

    // HTRANS[0] only distinguishes NONSEQ/SEQ and BUSY/IDLE, which are treated alike.
    assign unused_ok = ^{HTRANS[0], (TIMEOUT_CYC == 0)};

`ifdef AHB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    // Cycle counter for an outstanding request; held at zero outside REQ/RWAIT
    // so it is always clear on entry to REQ.
    always_ff @(posedge i_clk_ahb) begin
        if (reset || ((state != S_REQ) && (state != S_RWAIT))) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign timeout = ((state == S_REQ) || (state == S_RWAIT)) &&
                     (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk_ahb) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (!legal) begin
                        state_nxt = S_ERR1;
                    end else if (HWRITE) begin
                        state_nxt = S_WDATA;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WDATA: begin
                HREADYOUT = 1'b0;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                HREADYOUT = 1'b0;
                o_valid   = 1'b1;
                // A handshake completing in the same cycle as the timeout wins.
                if (i_ready) begin
                    if (o_rd0_wr1 || i_rd_valid) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_RWAIT;
                    end
                end else if (timeout) begin
                    state_nxt = S_ERR1;
                end
            end
            S_RWAIT: begin
                HREADYOUT = 1'b0;
                if (i_rd_valid) begin
                    state_nxt = S_RESP;
                end else if (timeout) begin
                    state_nxt = S_ERR1;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address/direction capture at accept, write data in the first data-phase
    // cycle, read data on completion of a read.
    always_ff @(posedge i_clk_ahb) begin
        if (reset) begin
            o_address <= '0;
            o_rd0_wr1 <= 1'b0;
            o_wr_data <= '0;
            HRDATA    <= '0;
        end else begin
            if (accept) begin
                o_address <= HADDR;
                o_rd0_wr1 <= HWRITE;
            end
            if (state == S_WDATA) begin
                o_wr_data <= HWDATA;
            end
            if (rd_capture) begin
                HRDATA <= i_rd_data;
            end
        end
    end

endmodule
